// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the fetch unit and the fetch sequencer state encoding.
package cpu_pkg;
    typedef enum logic [1:0] {S_RUN = 2'd0, S_HOLD = 2'd1, S_HALT = 2'd2} fetch_state_e;
    localparam logic [31:0] INI_ADDR  = 32'h0000_3000;
    localparam logic [31:0] FAULT_VEC = 32'h0000_4180;
    localparam int          IM_DEPTH  = 1024;
endpackage

// File: rtl/fetch_redir_buf.sv
// fetch_redir_buf: pending-redirect latch; capture overwrites, consume clears, flush drops.
module fetch_redir_buf
    import cpu_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        flush_i,
    input  logic        capture_i,
    input  logic        consume_i,
    input  logic [31:0] target_i,
    output logic        pend_valid_o,
    output logic [31:0] pend_target_o
);
    logic        valid_q, valid_d;
    logic [31:0] target_q, target_d;

    always_comb begin
        valid_d  = flush_i ? 1'b0 : capture_i ? 1'b1 : consume_i ? 1'b0 : valid_q;
        target_d = flush_i ? 32'd0 : capture_i ? target_i : target_q;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_q  <= 1'b0;
            target_q <= 32'd0;
        end else begin
            valid_q  <= valid_d;
            target_q <= target_d;
        end
    end

    assign pend_valid_o  = valid_q;
    assign pend_target_o = target_q;
endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: next-PC sequencer for the IFU (run/hold/halt, redirect latching, IF/ID enable).
// Optional target range/alignment check enabled by FETCH_SEQ_ALIGN_CHECK_EN.
module fetch_seq #(
    parameter logic [31:0] INI_ADDR  = cpu_pkg::INI_ADDR,
    parameter int          IM_DEPTH  = cpu_pkg::IM_DEPTH,
    parameter logic [31:0] FAULT_VEC = cpu_pkg::FAULT_VEC
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] PCNow,
    input  logic        Stall,
    input  logic        RedirValid,
    input  logic [31:0] RedirTarget,
    input  logic        HaltReq,
    output logic [31:0] PCNext,
    output logic        FetchValid,
    output logic        IFIDEn,
    output logic        Halted,
    output logic [31:0] FetchCount,
    output logic        Fault
);
    import cpu_pkg::*;

`ifdef FETCH_SEQ_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif
    localparam logic [31:0] END_ADDR = INI_ADDR + 32'(4 * IM_DEPTH);

    fetch_state_e state_q;
    logic [31:0]  count_q;
    logic         fault_q;
    logic         active, apply, bad, pend_valid;
    logic [31:0]  pend_target, tgt;

    // A pending redirect is older than a new one, so it is applied first.
    always_comb begin
        active = state_q != S_HALT;
        tgt    = pend_valid ? pend_target : RedirTarget;
        apply  = active & ~HaltReq & ~Stall & (pend_valid | RedirValid);
        bad    = ALIGN_EN & apply & ((tgt[1:0] != 2'b00) | (tgt < INI_ADDR) | (tgt >= END_ADDR));
        PCNext = Rst ? INI_ADDR :
                 (~active | Stall | HaltReq) ? PCNow :
                 bad ? FAULT_VEC :
                 apply ? tgt : PCNow + 32'd4;
        FetchValid = ~Rst & active;
        IFIDEn     = ~Rst & active & ~Stall;
        Halted     = ~Rst & ~active;
    end

    fetch_redir_buf u_redir_buf (
        .Clk          (Clk),
        .Rst          (Rst),
        .flush_i      (~active | HaltReq),
        .capture_i    (RedirValid & ~(apply & ~pend_valid)),
        .consume_i    (apply),
        .target_i     (RedirTarget),
        .pend_valid_o (pend_valid),
        .pend_target_o(pend_target)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_RUN;
            count_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            if (active) state_q <= HaltReq ? S_HALT : Stall ? S_HOLD : S_RUN;
            if (IFIDEn) count_q <= count_q + 32'd1;
            if (bad) fault_q <= 1'b1;
        end
    end

    assign FetchCount = count_q;
    assign Fault      = fault_q;
endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed self-checking bench for fetch_seq with a loop-back IFU PC register.
module tb_fetch_seq;
    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] PCNow;
    logic        Stall = 1'b0, RedirValid = 1'b0, HaltReq = 1'b0;
    logic [31:0] RedirTarget = 32'd0;
    logic [31:0] PCNext, FetchCount;
    logic        FetchValid, IFIDEn, Halted, Fault;
    int nvec = 0, nerr = 0;

    fetch_seq dut (
        .Clk(Clk), .Rst(Rst), .PCNow(PCNow), .Stall(Stall), .RedirValid(RedirValid),
        .RedirTarget(RedirTarget), .HaltReq(HaltReq), .PCNext(PCNext), .FetchValid(FetchValid),
        .IFIDEn(IFIDEn), .Halted(Halted), .FetchCount(FetchCount), .Fault(Fault)
    );

    always #5 Clk = ~Clk;
    always_ff @(posedge Clk) PCNow <= PCNext;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1; Stall = 1'b0; RedirValid = 1'b0; HaltReq = 1'b0; RedirTarget = 32'd0;
        tick(); tick();
        Rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        tick();
        nvec++; if (PCNext !== 32'h3000) begin nerr++; $display("FAIL reset_pc: got %h want %h", PCNext, 32'h3000); end
        nvec++; if (FetchValid !== 1'b0) begin nerr++; $display("FAIL reset_fv: got %b want 0", FetchValid); end
        nvec++; if (IFIDEn !== 1'b0) begin nerr++; $display("FAIL reset_en: got %b want 0", IFIDEn); end
        nvec++; if (Halted !== 1'b0) begin nerr++; $display("FAIL reset_halted: got %b want 0", Halted); end
        tick();
        nvec++; if (FetchCount !== 32'd0) begin nerr++; $display("FAIL reset_count: got %0d want 0", FetchCount); end
        nvec++; if (Fault !== 1'b0) begin nerr++; $display("FAIL reset_fault: got %b want 0", Fault); end
        Rst = 1'b0;
        #1;
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            nvec++; if (PCNext !== 32'h3004 + 32'(4 * i)) begin nerr++; $display("FAIL seq_pc%0d: got %h want %h", i, PCNext, 32'h3004 + 32'(4 * i)); end
            nvec++; if (IFIDEn !== 1'b1 || FetchValid !== 1'b1) begin nerr++; $display("FAIL seq_en%0d: got %b%b want 11", i, IFIDEn, FetchValid); end
            tick();
        end
        nvec++; if (FetchCount !== 32'd4) begin nerr++; $display("FAIL seq_count: got %0d want 4", FetchCount); end
    endtask

    task automatic test_stall();
        do_reset(); tick(); tick();
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            nvec++; if (PCNext !== 32'h3008) begin nerr++; $display("FAIL stall_pc%0d: got %h want %h", i, PCNext, 32'h3008); end
            nvec++; if (IFIDEn !== 1'b0) begin nerr++; $display("FAIL stall_en%0d: got %b want 0", i, IFIDEn); end
            tick();
        end
        Stall = 1'b0;
        #1;
        nvec++; if (PCNext !== 32'h300C) begin nerr++; $display("FAIL stall_rel_pc: got %h want %h", PCNext, 32'h300C); end
        nvec++; if (IFIDEn !== 1'b1) begin nerr++; $display("FAIL stall_rel_en: got %b want 1", IFIDEn); end
        tick();
        nvec++; if (FetchCount !== 32'd3) begin nerr++; $display("FAIL stall_count: got %0d want 3", FetchCount); end
    endtask

    task automatic test_redirect_stall();
        do_reset(); tick(); tick();
        Stall = 1'b1; RedirValid = 1'b1; RedirTarget = 32'h3040;
        #1;
        nvec++; if (PCNext !== 32'h3008) begin nerr++; $display("FAIL rstall_hold: got %h want %h", PCNext, 32'h3008); end
        tick();
        RedirValid = 1'b0;
        tick();
        Stall = 1'b0;
        #1;
        nvec++; if (PCNext !== 32'h3040) begin nerr++; $display("FAIL rstall_apply: got %h want %h", PCNext, 32'h3040); end
        tick();
        nvec++; if (PCNext !== 32'h3044) begin nerr++; $display("FAIL rstall_clear: got %h want %h", PCNext, 32'h3044); end
    endtask

    task automatic test_overwrite();
        do_reset(); tick(); tick();
        Stall = 1'b1; RedirValid = 1'b1; RedirTarget = 32'h3040;
        tick();
        RedirTarget = 32'h3080;
        tick();
        RedirValid = 1'b0; Stall = 1'b0;
        #1;
        nvec++; if (PCNext !== 32'h3080) begin nerr++; $display("FAIL overwrite: got %h want %h", PCNext, 32'h3080); end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset(); tick(); tick();
        Stall = 1'b1; RedirValid = 1'b1; RedirTarget = 32'h3040;
        tick();
        Stall = 1'b0; RedirTarget = 32'h3100;
        #1;
        nvec++; if (PCNext !== 32'h3040) begin nerr++; $display("FAIL b2b_first: got %h want %h", PCNext, 32'h3040); end
        tick();
        RedirValid = 1'b0;
        #1;
        nvec++; if (PCNext !== 32'h3100) begin nerr++; $display("FAIL b2b_second: got %h want %h", PCNext, 32'h3100); end
        tick();
        nvec++; if (PCNext !== 32'h3104) begin nerr++; $display("FAIL b2b_after: got %h want %h", PCNext, 32'h3104); end
        RedirValid = 1'b1; RedirTarget = 32'h3200;
        #1;
        nvec++; if (PCNext !== 32'h3200 || IFIDEn !== 1'b1) begin nerr++; $display("FAIL direct_redir: got %h/%b want %h/1", PCNext, IFIDEn, 32'h3200); end
        tick();
        RedirValid = 1'b0;
        #1;
        nvec++; if (PCNext !== 32'h3204) begin nerr++; $display("FAIL direct_after: got %h want %h", PCNext, 32'h3204); end
    endtask

    task automatic test_halt();
        do_reset(); tick();
        HaltReq = 1'b1; RedirValid = 1'b1; RedirTarget = 32'h3100;
        #1;
        nvec++; if (PCNext !== 32'h3004) begin nerr++; $display("FAIL halt_req_pc: got %h want %h", PCNext, 32'h3004); end
        tick();
        HaltReq = 1'b0; RedirValid = 1'b0;
        #1;
        nvec++; if (Halted !== 1'b1 || FetchValid !== 1'b0 || IFIDEn !== 1'b0) begin nerr++; $display("FAIL halt_flags: got %b%b%b want 100", Halted, FetchValid, IFIDEn); end
        nvec++; if (PCNext !== 32'h3004) begin nerr++; $display("FAIL halt_pc: got %h want %h", PCNext, 32'h3004); end
        RedirValid = 1'b1; RedirTarget = 32'h3200;
        tick(); tick();
        RedirValid = 1'b0;
        #1;
        nvec++; if (PCNext !== 32'h3004) begin nerr++; $display("FAIL halt_frozen: got %h want %h", PCNext, 32'h3004); end
        nvec++; if (FetchCount !== 32'd2) begin nerr++; $display("FAIL halt_count: got %0d want 2", FetchCount); end
        Rst = 1'b1;
        #1;
        nvec++; if (PCNext !== 32'h3000 || Halted !== 1'b0) begin nerr++; $display("FAIL halt_rst: got %h/%b want %h/0", PCNext, Halted, 32'h3000); end
        tick();
        Rst = 1'b0;
        #1;
        nvec++; if (FetchCount !== 32'd0 || PCNext !== 32'h3004) begin nerr++; $display("FAIL halt_exit: got %0d/%h want 0/%h", FetchCount, PCNext, 32'h3004); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset(); tick();
        Stall = 1'b1; RedirValid = 1'b1; RedirTarget = 32'h3040;
        tick();
        RedirValid = 1'b0; Rst = 1'b1;
        tick();
        Rst = 1'b0; Stall = 1'b0;
        #1;
        nvec++; if (PCNext !== 32'h3004) begin nerr++; $display("FAIL rst_stall_pend: got %h want %h", PCNext, 32'h3004); end
    endtask

    task automatic test_fault();
        do_reset();
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
        RedirValid = 1'b1; RedirTarget = 32'h3002;
        #1;
        nvec++; if (PCNext !== 32'h4180) begin nerr++; $display("FAIL fault_align_pc: got %h want %h", PCNext, 32'h4180); end
        tick();
        RedirTarget = 32'h3040;
        #1;
        nvec++; if (Fault !== 1'b1 || PCNext !== 32'h3040) begin nerr++; $display("FAIL fault_sticky: got %b/%h want 1/%h", Fault, PCNext, 32'h3040); end
        tick();
        RedirTarget = 32'h5000;
        #1;
        nvec++; if (PCNext !== 32'h4180) begin nerr++; $display("FAIL fault_range_pc: got %h want %h", PCNext, 32'h4180); end
        tick();
        RedirValid = 1'b0;
        do_reset();
        nvec++; if (Fault !== 1'b0) begin nerr++; $display("FAIL fault_clear: got %b want 0", Fault); end
`else
        RedirValid = 1'b1; RedirTarget = 32'hFFFF_FFFC;
        #1;
        nvec++; if (PCNext !== 32'hFFFF_FFFC) begin nerr++; $display("FAIL verbatim_pc: got %h want %h", PCNext, 32'hFFFF_FFFC); end
        tick();
        RedirValid = 1'b0;
        #1;
        nvec++; if (PCNext !== 32'h0000_0000) begin nerr++; $display("FAIL wrap_pc: got %h want %h", PCNext, 32'h0); end
        nvec++; if (Fault !== 1'b0) begin nerr++; $display("FAIL fault_tied: got %b want 0", Fault); end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_overwrite();
        test_back_to_back();
        test_halt();
        test_reset_mid_stall();
        test_fault();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
